// File: rtl/dmac_fifo_unpacker.sv
// rtl/dmac_fifo_unpacker.sv - drains packed 32-bit FIFO words into byte/half/word destination beats
module dmac_fifo_unpacker #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [1:0]            dst_width,
  input  logic [CNT_WIDTH-1:0]  trans_cnt,
  input  logic                  abort,
  input  logic                  fifo_empty,
  input  logic [31:0]           fifo_rd_data,
  output logic                  fifo_rd,
  output logic                  fifo_clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [31:0]           out_data,
  output logic [1:0]            out_size,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [31:0]            hold;
  logic [2:0]             bytes;
  logic [CNT_WIDTH-1:0]   remaining;
  logic [1:0]             size_q;
  logic                   clr_q;
  logic [2:0]             step;
  logic                   start_ok;
  logic                   handshake;
  logic                   last_beat;
  logic                   word_used;

  // size_q only ever holds 0/1/2; reserved width 3 is folded to word at latch time
  always_comb begin
    case (size_q)
      2'd0:    step = 3'd1;
      2'd1:    step = 3'd2;
      default: step = 3'd4;
    endcase
  end

  assign start_ok  = (state == IDLE) && start && !abort;
  assign handshake = (state == XFER) && out_ready && !abort;
  assign last_beat = (remaining == CNT_WIDTH'(1));
  assign word_used = (bytes == step);

  always_comb begin
    state_nxt = state;
    fifo_rd   = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_nxt = (trans_cnt == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (!fifo_empty) begin
          fifo_rd   = 1'b1;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (handshake) begin
          if (last_beat) begin
            state_nxt = DONE;
          end else if (word_used) begin
            // refill in the same cycle keeps a word-width stream gap-free
            if (!fifo_empty) begin
              fifo_rd = 1'b1;
            end else begin
              state_nxt = FETCH;
            end
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      hold      <= '0;
      bytes     <= '0;
      remaining <= '0;
      size_q    <= '0;
      out_addr  <= '0;
      clr_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      clr_q <= abort && (state != IDLE);
      if (start_ok) begin
        out_addr  <= dst_addr;
        size_q    <= (dst_width == 2'd3) ? 2'd2 : dst_width;
        remaining <= trans_cnt;
        bytes     <= '0;
      end
      if (fifo_rd) begin
        hold  <= fifo_rd_data;
        bytes <= 3'd4;
      end else if (handshake) begin
        hold  <= hold >> {step, 3'b000};
        bytes <= bytes - step;
      end
      if (handshake) begin
        remaining <= remaining - CNT_WIDTH'(1);
        out_addr  <= out_addr + ADDR_WIDTH'(step);
      end
    end
  end

  always_comb begin
    case (size_q)
      2'd0:    out_data = {4{hold[7:0]}};
      2'd1:    out_data = {2{hold[15:0]}};
      default: out_data = hold;
    endcase
  end

  assign out_size  = size_q;
  assign out_valid = (state == XFER);
  assign out_last  = (state == XFER) && last_beat;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign fifo_clr  = (state == DONE) || clr_q;

endmodule

// File: doc/dmac_fifo_unpacker.md
Name: dmac_fifo_unpacker

Overview:
- Drain stage directly downstream of the channel's synchronous data FIFO.
- Pops 32-bit little-endian packed words from the FIFO and splits them into destination-width beats (byte, half, word).
- Presents each beat with an incrementing destination address on a valid/ready interface to the destination bus master.
- Signals completion and clears the FIFO at end of transaction or on abort.

Parameters:
- ADDR_WIDTH, 32, destination address width; address arithmetic wraps modulo 2^ADDR_WIDTH.
- CNT_WIDTH, 16, width of destination transfer count.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset
- start  in  1  one-cycle pulse; latches dst_addr, dst_width, trans_cnt; ignored while busy=1
- dst_addr  in  ADDR_WIDTH  first destination address; must be aligned to dst_width (not checked)
- dst_width  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
- trans_cnt  in  CNT_WIDTH  number of destination beats
- abort  in  1  synchronous channel abort
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_data  in  32  FIFO head word (combinational read)
- fifo_rd  out  1  FIFO pop strobe
- fifo_clr  out  1  one-cycle FIFO clear pulse
- out_valid  out  1  beat valid
- out_ready  in  1  beat accepted when out_valid && out_ready
- out_addr  out  ADDR_WIDTH  beat address
- out_data  out  32  beat data, replicated across lanes: byte {4{b}}, half {2{h}}, word as-is
- out_size  out  2  beat size, same encoding as dst_width (3 is output as 2)
- out_last  out  1  final beat of the transaction
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at normal completion

Behaviour:
- Reset is asynchronous and active-low (reset_n), clock is clk. Reset values: state IDLE; fifo_rd=0, fifo_clr=0, out_valid=0, out_addr=0, out_data=0, out_size=0, out_last=0, busy=0, done=0. Holding register, byte count and remaining count are all 0.
- State machine: IDLE, FETCH, XFER, DONE.
- IDLE:
  - start with trans_cnt!=0 -> FETCH, busy=1.
  - start with trans_cnt==0 -> DONE directly.
- FETCH:
  - fifo_rd = !fifo_empty (combinational).
  - On a pop: hold<=fifo_rd_data, bytes<=4, go to XFER.
  - While the FIFO is empty: wait with no timeout.
- XFER:
  - out_valid=1. out_data is the low S bytes of hold, replicated. S = 1/2/4.
  - out_last=(remaining==1).
  - On handshake: hold>>=8*S, bytes-=S, remaining-=1, out_addr+=S.
- After a handshake in XFER:
  - remaining reaches 0 -> DONE. Unconsumed bytes in hold are discarded.
  - bytes reaches 0, remaining>0 and !fifo_empty -> same-cycle refill: fifo_rd=1, hold<=fifo_rd_data, bytes<=4, stay in XFER. This gives a gap-free word stream.
  - bytes reaches 0, remaining>0 and fifo_empty -> FETCH; out_valid deasserts next cycle.
- Output stability: out_valid, once high, holds with stable addr/data/size/last until the handshake. This does not apply to abort.
- DONE: one cycle.
  - done=1 on normal completion only; fifo_clr=1; busy=0 the following cycle; then IDLE.
- Abort has highest priority, in any state other than IDLE:
  - next cycle: IDLE, out_valid=0, busy=0, fifo_clr=1 for one cycle, done=0.
  - No fifo_rd in the abort cycle.
  - abort in IDLE has no effect.
- start coincident with abort: abort wins, start dropped.
- fifo_rd is never asserted when fifo_empty=1.
- Pop limit: at most ceil(trans_cnt*S/4) pops per transaction.

Test Plan:
- Word stream: dst_addr=0x1000, width=2, trans_cnt=3; FIFO holds 0x11223344, 0x55667788, 0xAABBCCDD; out_ready=1 -> beats at 0x1000/0x1004/0x1008 on consecutive cycles, out_last on the third, done pulse, fifo_clr pulse, 3 pops.
- Byte split: width=0, addr=0x20, trans_cnt=5; words 0x44332211, 0x88776655 -> data 0x11111111, 0x22222222, 0x33333333, 0x44444444, 0x55555555 at 0x20..0x24, 2 pops. Leftover bytes are discarded.
- Half with backpressure: width=1, trans_cnt=2, word 0xBEEFCAFE; out_ready low 3 cycles -> beat 0xCAFECAFE held stable, then 0xBEEFBEEF; one pop.
- FIFO underrun: width=2, trans_cnt=2, second word arrives 5 cycles late -> out_valid low during the gap, no fifo_rd while empty, correct second beat.
- Abort mid-transfer: trans_cnt=8, abort after 2 beats -> next cycle out_valid=0, busy=0, fifo_clr=1, done=0. A subsequent start works normally.
- Corner cases:
  - trans_cnt=0 -> done next cycle, no pops, no beats.
  - Address wrap at 0xFFFFFFFC with a word beat -> next address 0x00000000.
  - start while busy -> ignored.
